// File: rtl/mem_copy_engine.sv
// mem_copy_engine
// ---------------------------------------------------------------------------
// Bus-master block copier. It drives the single-port data-memory interface and
// moves `length` words from `src_addr` to `dst_addr`. Each word takes one read
// cycle followed by one write cycle, in ascending address order. A one-cycle
// `done` pulse marks the end of the transfer.
//
// Optional build macro: CPY_CHECKSUM_EN
//   When defined, the block gains a `checksum` output. It holds the sum,
//   modulo 2^DATA_W, of every word read during the last transfer.
//
// Ports
//   clk        system clock, all state updates on posedge
//   rst_n      asynchronous active-low reset
//   start      transfer request, only sampled in IDLE
//   src_addr   first source word address (captured on accepted start)
//   dst_addr   first destination word address (captured on accepted start)
//   length     number of words to copy (captured on accepted start)
//   busy       high while a read or write cycle is on the bus
//   done       one-cycle completion pulse
//   address    memory address
//   WriteData  memory write data
//   MemRead    memory read enable
//   MemWrite   memory write enable (memory commits on posedge)
//   ReadData   combinational read data from memory
//   checksum   (CPY_CHECKSUM_EN only) running sum of words read
// ---------------------------------------------------------------------------
module mem_copy_engine #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] WriteData,
    output logic              MemRead,
    output logic              MemWrite,
    input  logic [DATA_W-1:0] ReadData
`ifdef CPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] src_reg;
    logic [ADDR_W-1:0] dst_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  idx_reg;
    logic [DATA_W-1:0] buf_reg;
    // Outside the bus cycles the port shows the last address/data driven,
    // so those values are kept in hold registers.
    logic [ADDR_W-1:0] addr_hold_reg;
    logic [DATA_W-1:0] wdata_hold_reg;

    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [LEN_W-1:0]  idx_next;
    logic              last_word;

    // Addresses wrap naturally through truncation to ADDR_W bits.
    assign rd_addr   = src_reg + ADDR_W'(idx_reg);
    assign wr_addr   = dst_reg + ADDR_W'(idx_reg);
    assign idx_next  = idx_reg + LEN_W'(1);
    assign last_word = (idx_next == len_reg);

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        address    = addr_hold_reg;
        WriteData  = wdata_hold_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (length != '0) ? READ : DONE;
                end
            end
            READ: begin
                busy       = 1'b1;
                MemRead    = 1'b1;
                address    = rd_addr;
                state_next = WRITE;
            end
            WRITE: begin
                busy       = 1'b1;
                MemWrite   = 1'b1;
                address    = wr_addr;
                WriteData  = buf_reg;
                state_next = last_word ? DONE : READ;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef CPY_CHECKSUM_EN
    logic [DATA_W-1:0] sum_reg;
    assign checksum = sum_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            src_reg        <= '0;
            dst_reg        <= '0;
            len_reg        <= '0;
            idx_reg        <= '0;
            buf_reg        <= '0;
            addr_hold_reg  <= '0;
            wdata_hold_reg <= '0;
`ifdef CPY_CHECKSUM_EN
            sum_reg        <= '0;
`endif
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        src_reg <= src_addr;
                        dst_reg <= dst_addr;
                        len_reg <= length;
                        idx_reg <= '0;
`ifdef CPY_CHECKSUM_EN
                        sum_reg <= '0;
`endif
                    end
                end
                READ: begin
                    buf_reg       <= ReadData;
                    addr_hold_reg <= rd_addr;
`ifdef CPY_CHECKSUM_EN
                    sum_reg       <= sum_reg + ReadData;
`endif
                end
                WRITE: begin
                    idx_reg        <= idx_next;
                    addr_hold_reg  <= wr_addr;
                    wdata_hold_reg <= buf_reg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine. It contains a behavioural memory
// responder and a reference memory image. Every expected bus access is pushed
// to a scoreboard queue when a transfer starts, and each access is popped and
// compared as it appears on the bus.
module tb_mem_copy_engine;
    localparam int AW = 13;
    localparam int DW = 16;
    localparam int LW = 13;
    localparam int MEM_WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [LW-1:0] length = '0;
    logic          busy, done, MemRead, MemWrite;
    logic [AW-1:0] address;
    logic [DW-1:0] WriteData;
    logic [DW-1:0] ReadData;
`ifdef CPY_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    mem_copy_engine #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .address  (address),
        .WriteData(WriteData),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .ReadData (ReadData)
`ifdef CPY_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem     [0:MEM_WORDS-1];
    logic [DW-1:0] ref_mem [0:MEM_WORDS-1];

    assign ReadData = mem[address];
    always @(posedge clk) if (MemWrite) mem[address] <= WriteData;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;
    acc_t exp_q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic preload(input int a, input logic [DW-1:0] v);
        mem[a] <= v;
        ref_mem[a] = v;
    endtask

    function automatic int mem_diffs();
        int n = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    // Runs one transfer and watches the bus cycle by cycle (c=1 is cycle T+1).
    // model_words: number of words the reference image commits.
    // restart_c: cycle to pulse a spurious start; reset_c: cycle to drop rst_n.
    task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [LW-1:0] n, input int model_words,
                            input int restart_c, input int reset_c,
                            output int done_c, output int ndone,
                            output int busy_c, output int mem_c,
                            output logic [DW-1:0] sum);
        logic [AW-1:0] sa, da;
        logic [DW-1:0] v;
        acc_t e;
        int budget;
        sum = '0;
        done_c = -1; ndone = 0; busy_c = 0; mem_c = 0;
        exp_q.delete();
        for (int k = 0; k < int'(n); k++) begin
            sa = s + AW'(k);
            da = d + AW'(k);
            v  = ref_mem[sa];
            sum = sum + v;
            if (k < model_words) ref_mem[da] = v;
            exp_q.push_back('{1'b0, sa, {DW{1'b0}}});
            exp_q.push_back('{1'b1, da, v});
        end
        budget = 2 * int'(n) + 3;
        @(negedge clk);
        src_addr = s; dst_addr = d; length = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            if (c == reset_c) begin
                rst_n = 1'b0;
                #1;
                total_cnt++;
                if ({busy, done, MemRead, MemWrite} !== 4'b0 || address !== '0 || WriteData !== '0)
                    $display("FAIL reset_outputs: busy=%b done=%b rd=%b wr=%b addr=%0d wdata=%h, expected all zero",
                             busy, done, MemRead, MemWrite, address, WriteData);
                else pass_cnt++;
                exp_q.delete();
                break;
            end
            if (c == restart_c) begin
                start = 1'b1;
                src_addr = s + AW'(7);
                dst_addr = d + AW'(3);
                length = LW'(2);
            end else if (c == restart_c + 1) begin
                start = 1'b0;
            end
            if (done) begin ndone++; done_c = c; end
            if (busy) busy_c++;
            if (MemRead || MemWrite) begin
                mem_c++;
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL access: unexpected rd=%b wr=%b addr=%0d in cycle T+%0d, expected no access",
                             MemRead, MemWrite, address, c);
                end else begin
                    e = exp_q.pop_front();
                    if (MemRead !== !e.wr || MemWrite !== e.wr || address !== e.addr ||
                        (e.wr && WriteData !== e.data))
                        $display("FAIL access: got rd=%b wr=%b addr=%0d wdata=%h, expected wr=%b addr=%0d wdata=%h (cycle T+%0d)",
                                 MemRead, MemWrite, address, WriteData, e.wr, e.addr, e.data, c);
                    else pass_cnt++;
                end
            end
            @(posedge clk); #1;
        end
        if (reset_c < 0) begin
            total_cnt++;
            if (exp_q.size() != 0)
                $display("FAIL scoreboard_drain: %0d accesses missing, expected 0", exp_q.size());
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({busy, done, MemRead, MemWrite} !== 4'b0 || address !== '0 || WriteData !== '0)
            $display("FAIL reset_state: busy=%b done=%b rd=%b wr=%b addr=%0d wdata=%h, expected all zero",
                     busy, done, MemRead, MemWrite, address, WriteData);
        else pass_cnt++;
`ifdef CPY_CHECKSUM_EN
        total_cnt++;
        if (checksum !== '0) $display("FAIL reset_checksum: got %h expected 0000", checksum);
        else pass_cnt++;
`endif
        rst_n = 1'b1;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int dc, nd, bc, mc;
        logic [DW-1:0] s;
        preload(100, 16'd10);
        for (int i = 1; i < 10; i++) preload(100 + i, DW'(i + 1));
        run_copy(13'd100, 13'd150, 13'd10, 10, -1, -1, dc, nd, bc, mc, s);
        total_cnt++;
        if (dc !== 21 || nd !== 1) $display("FAIL basic_done: cycle T+%0d count %0d, expected T+21 count 1", dc, nd);
        else pass_cnt++;
        total_cnt++;
        if (bc !== 20 || mc !== 20) $display("FAIL basic_busy: busy %0d mem %0d, expected 20 20", bc, mc);
        else pass_cnt++;
        total_cnt++;
        if (mem_diffs() != 0) $display("FAIL basic_mem: %0d words differ, expected 0", mem_diffs());
        else pass_cnt++;
`ifdef CPY_CHECKSUM_EN
        total_cnt++;
        if (checksum !== 16'h0040) $display("FAIL basic_checksum: got %h expected 0040", checksum);
        else pass_cnt++;
`endif
        $display("test_basic: done at T+%0d, %0d bus cycles, sum %h", dc, mc, s);
    endtask

    task automatic test_zero_length();
        int dc, nd, bc, mc;
        logic [DW-1:0] s;
        run_copy(13'd5, 13'd20, 13'd0, 0, -1, -1, dc, nd, bc, mc, s);
        total_cnt++;
        if (dc !== 1 || nd !== 1) $display("FAIL zero_done: cycle T+%0d count %0d, expected T+1 count 1", dc, nd);
        else pass_cnt++;
        total_cnt++;
        if (mc !== 0 || bc !== 0) $display("FAIL zero_access: mem %0d busy %0d, expected 0 0", mc, bc);
        else pass_cnt++;
        total_cnt++;
        if (mem_diffs() != 0) $display("FAIL zero_mem: %0d words differ, expected 0", mem_diffs());
        else pass_cnt++;
`ifdef CPY_CHECKSUM_EN
        total_cnt++;
        if (checksum !== '0) $display("FAIL zero_checksum: got %h expected 0000", checksum);
        else pass_cnt++;
`endif
        $display("test_zero_length: done at T+%0d", dc);
    endtask

    task automatic test_wrap();
        int dc, nd, bc, mc;
        logic [DW-1:0] s;
        preload(8190, 16'hAAAA);
        preload(8191, 16'hBBBB);
        preload(0, 16'hCCCC);
        run_copy(13'd8190, 13'd40, 13'd3, 3, -1, -1, dc, nd, bc, mc, s);
        total_cnt++;
        if (dc !== 7) $display("FAIL wrap_done: cycle T+%0d expected T+7", dc);
        else pass_cnt++;
        total_cnt++;
        if (mem[40] !== 16'hAAAA || mem[41] !== 16'hBBBB || mem[42] !== 16'hCCCC || mem_diffs() != 0)
            $display("FAIL wrap_mem: got %h %h %h expected AAAA BBBB CCCC", mem[40], mem[41], mem[42]);
        else pass_cnt++;
`ifdef CPY_CHECKSUM_EN
        total_cnt++;
        if (checksum !== 16'h3331) $display("FAIL wrap_checksum: got %h expected 3331", checksum);
        else pass_cnt++;
`endif
        $display("test_wrap: done at T+%0d, sum %h", dc, s);
    endtask

    task automatic test_overlap();
        int dc, nd, bc, mc;
        logic [DW-1:0] s;
        for (int i = 0; i < 4; i++) preload(100 + i, DW'(i + 1));
        run_copy(13'd100, 13'd101, 13'd3, 3, -1, -1, dc, nd, bc, mc, s);
        total_cnt++;
        if (mem[100] !== 16'd1 || mem[101] !== 16'd1 || mem[102] !== 16'd1 || mem[103] !== 16'd1)
            $display("FAIL overlap_mem: got %0d %0d %0d %0d expected 1 1 1 1", mem[100], mem[101], mem[102], mem[103]);
        else pass_cnt++;
        total_cnt++;
        if (mem_diffs() != 0) $display("FAIL overlap_image: %0d words differ, expected 0", mem_diffs());
        else pass_cnt++;
        $display("test_overlap: done at T+%0d", dc);
    endtask

    task automatic test_ignored_start();
        int dc, nd, bc, mc;
        logic [DW-1:0] s;
        for (int i = 0; i < 4; i++) preload(200 + i, DW'(16'h1200 + i));
        run_copy(13'd200, 13'd300, 13'd4, 4, 3, -1, dc, nd, bc, mc, s);
        total_cnt++;
        if (mc !== 8 || nd !== 1 || dc !== 9)
            $display("FAIL ignored_start: mem %0d done count %0d at T+%0d, expected 8 1 T+9", mc, nd, dc);
        else pass_cnt++;
        total_cnt++;
        if (mem_diffs() != 0) $display("FAIL ignored_mem: %0d words differ, expected 0", mem_diffs());
        else pass_cnt++;
        $display("test_ignored_start: %0d bus cycles, %0d done pulses", mc, nd);
    endtask

    task automatic test_back_to_back();
        int dc, nd, bc, mc;
        logic [DW-1:0] s;
        run_copy(13'd300, 13'd400, 13'd4, 4, -1, -1, dc, nd, bc, mc, s);
        total_cnt++;
        if (dc !== 9 || nd !== 1 || mc !== 8)
            $display("FAIL back_to_back: done T+%0d count %0d mem %0d, expected T+9 1 8", dc, nd, mc);
        else pass_cnt++;
        total_cnt++;
        if (mem_diffs() != 0) $display("FAIL back_mem: %0d words differ, expected 0", mem_diffs());
        else pass_cnt++;
        $display("test_back_to_back: done at T+%0d", dc);
    endtask

    task automatic test_reset_abort();
        int dc, nd, bc, mc;
        int seen_done;
        logic [DW-1:0] s;
        for (int i = 0; i < 5; i++) preload(500 + i, DW'(16'h5000 + i));
        run_copy(13'd500, 13'd600, 13'd5, 2, -1, 6, dc, nd, bc, mc, s);
        seen_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        total_cnt++;
        if (nd !== 0 || seen_done !== 0 || mc !== 5)
            $display("FAIL abort_done: done %0d late activity %0d mem %0d, expected 0 0 5", nd, seen_done, mc);
        else pass_cnt++;
        total_cnt++;
        if (mem_diffs() != 0) $display("FAIL abort_mem: %0d words differ, expected 0", mem_diffs());
        else pass_cnt++;
`ifdef CPY_CHECKSUM_EN
        total_cnt++;
        if (checksum !== '0) $display("FAIL abort_checksum: got %h expected 0000", checksum);
        else pass_cnt++;
`endif
        run_copy(13'd600, 13'd700, 13'd2, 2, -1, -1, dc, nd, bc, mc, s);
        total_cnt++;
        if (dc !== 5 || nd !== 1 || mem_diffs() != 0)
            $display("FAIL abort_restart: done T+%0d count %0d diffs %0d, expected T+5 1 0", dc, nd, mem_diffs());
        else pass_cnt++;
        $display("test_reset_abort: restart done at T+%0d", dc);
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i] <= DW'(i) ^ 16'h5A5A;
            ref_mem[i] = DW'(i) ^ 16'h5A5A;
        end
        test_reset();
        test_basic();
        test_zero_length();
        test_wrap();
        test_overlap();
        test_ignored_start();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within 200000 time units");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Bus-master block copier: initiator on the single-port data-memory interface (address / WriteData / MemRead / MemWrite / ReadData) that the memory module answers as responder.
- Given source address, destination address and word count, it issues alternating read/write cycles to copy the block, then pulses done.
- Sits beside the CPU datapath; the top level muxes its memory-port outputs with the CPU's, selected by busy.

Parameters:
ADDR_W, 13, memory address width; addresses wrap modulo 2^ADDR_W
DATA_W, 16, memory word width
LEN_W, 13, width of the length field (max words per transfer = 2^LEN_W - 1)

Ports:
clk  input  1  system clock, all state updates on posedge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a transfer; sampled only in IDLE
src_addr  input  ADDR_W  first source word address, captured on accepted start
dst_addr  input  ADDR_W  first destination word address, captured on accepted start
length  input  LEN_W  number of words to copy, captured on accepted start
busy  output  1  high while in READ or WRITE
done  output  1  one-cycle completion pulse
address  output  ADDR_W  memory address
WriteData  output  DATA_W  memory write data
MemRead  output  1  memory read enable
MemWrite  output  1  memory write enable (memory commits on posedge)
ReadData  input  DATA_W  combinational read data from memory

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, MemRead=0, MemWrite=0, address=0, WriteData=0; internal src/dst/count/buffer cleared. Reset mid-transfer aborts immediately: no further writes, no done pulse.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: start=1 latches src_addr, dst_addr and length, and clears word index i. Next state is READ if length!=0, else DONE. start=0 stays IDLE.
- READ: MemRead=1, MemWrite=0, address=src+i (ADDR_W wrap). At posedge, latch ReadData into buffer. Next state is WRITE.
- WRITE: MemWrite=1, MemRead=0, address=dst+i (wrap), WriteData=buffer. At posedge, i<=i+1. If i+1==length, next state is DONE, else READ.
- DONE: done=1 for exactly one cycle, busy=0, both enables 0. Next state is IDLE.
- Outputs are decoded from registered state and counters only; no combinational path from start to any memory-port output.
- Latency: start accepted at edge T. Word k is read in cycle T+1+2k and written in cycle T+2+2k. done is high in cycle T+2N+1. Zero length: done is high in cycle T+1 with no memory access.
- Outside READ/WRITE: MemRead=MemWrite=0, address and WriteData hold their last values.
- start during READ/WRITE/DONE is ignored (not queued). start in the same cycle DONE returns to IDLE is ignored; start must be seen in IDLE.
- Overlap: strictly forward copy, ascending i. If dst is in (src, src+length), already-copied words propagate; this is the defined behaviour, not an error.
- Address wrap: src+i and dst+i are truncated to ADDR_W bits; 8191 -> 0 is legal.

Optional Feature:
- Macro CPY_CHECKSUM_EN.
- Defined: adds output port checksum [DATA_W-1:0], reset 0. It clears to 0 on an accepted start and adds each latched read word modulo 2^DATA_W at the READ posedge. It holds its final value from the DONE cycle until the next accepted start.
- Undefined: port and accumulator are absent; all other behaviour is identical.

Test Plan:
- Preload mem[100..109]={10,2,3,4,5,6,7,8,9,10}; start src=100 dst=150 length=10 -> mem[150..159] equal the source; done high exactly in cycle T+21; busy high cycles T+1..T+20; with CPY_CHECKSUM_EN, checksum=64 (0x0040).
- start with length=0, src=5, dst=20 -> done in cycle T+1; MemRead and MemWrite never asserted; memory unchanged.
- Preload mem[8190]=0xAAAA, mem[8191]=0xBBBB, mem[0]=0xCCCC; start src=8190 dst=40 length=3 -> mem[40..42]={0xAAAA,0xBBBB,0xCCCC}; address sequence 8190,40,8191,41,0,42.
- Overlap: mem[100..103]={1,2,3,4}; start src=100 dst=101 length=3 -> mem[100..103]={1,1,1,1}.
- Pulse start again during cycle T+3 of a 4-word transfer -> ignored; exactly 8 memory cycles and one done pulse; a later start in IDLE is accepted normally.
- Drop rst_n low during the WRITE of word 2 of 5 -> outputs zero immediately, only words 0-1 written, no done pulse; after release the block is in IDLE and accepts a new start.
